// File: rtl/fetch_pkg.sv
// Shared defaults and types for the fetch stage: widths, reset PC, halt opcode, FSM state.
// The optional halt-on-opcode behaviour is enabled by defining FETCH_HALT_OPCODE_EN.
package fetch_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 8;

  localparam logic [PC_W_DEF-1:0]    RESET_PC_DEF    = 8'h00;
  localparam logic [INSTR_W_DEF-1:0] HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Bus between the fetch stage and its neighbours: instruction memory port,
// decoder handshake, redirect and halt control.
interface fetch_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
);

  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_in;
  logic [INSTR_W-1:0] ir_out;
  logic [PC_W-1:0]    ir_pc;
  logic               ir_valid;
  logic               dec_ready;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt_req;
  logic               resume;
  logic               halted;

  modport master (
    output pc_out, ir_out, ir_pc, ir_valid, halted,
    input  instr_in, dec_ready, redirect, redirect_pc, halt_req, resume
  );

  modport slave (
    input  pc_out, ir_out, ir_pc, ir_valid, halted,
    output instr_in, dec_ready, redirect, redirect_pc, halt_req, resume
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection: redirect beats increment, increment beats hold.
// Increment wraps modulo 2**PC_W.
module fetch_next_pc #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc_q,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            fetch_fire,
  output logic [PC_W-1:0] pc_d
);

  // priority mux for the program counter
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (fetch_fire) begin
      pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC + instruction register with valid/ready delivery, redirect and RUN/HALT control.
// Define FETCH_HALT_OPCODE_EN to make a fetched HALT_OPCODE enter HALT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_W        = PC_W_DEF,
  parameter int                  INSTR_W     = INSTR_W_DEF,
`ifdef FETCH_HALT_OPCODE_EN
  parameter logic [INSTR_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF,
`endif
  parameter logic [PC_W-1:0]     RESET_PC    = RESET_PC_DEF
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.master bus
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_out_q, ir_out_d;
  logic [PC_W-1:0]    ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               halted_q, halted_d;
  logic               ir_free_s;
  logic               fetch_fire_s;
  logic               op_halt_s;

  // handshake decode: a fetch needs RUN, a free IR and no competing redirect/halt request
  always_comb begin
    ir_free_s    = !ir_valid_q || bus.dec_ready;
    fetch_fire_s = (state_q == RUN) && ir_free_s && !bus.redirect && !bus.halt_req;
`ifdef FETCH_HALT_OPCODE_EN
    op_halt_s    = fetch_fire_s && (bus.instr_in == HALT_OPCODE);
`else
    op_halt_s    = 1'b0;
`endif
  end

  fetch_next_pc #(
    .PC_W (PC_W)
  ) u_next_pc (
    .pc_q        (pc_q),
    .redirect    (bus.redirect),
    .redirect_pc (bus.redirect_pc),
    .fetch_fire  (fetch_fire_s),
    .pc_d        (pc_d)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; redirect never changes the state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.halt_req || op_halt_s) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        if (bus.resume && !bus.halt_req) begin
          state_d = RUN;
        end else begin
          state_d = HALT;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // FSM output: halted follows the state it is registered alongside
  always_comb begin
    halted_d = (state_d == HALT);
  end

  // IR next values: redirect squashes, fetch refills, delivery without refill empties
  always_comb begin
    ir_out_d   = ir_out_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    if (bus.redirect) begin
      ir_valid_d = 1'b0;
    end else if (fetch_fire_s) begin
      ir_out_d   = bus.instr_in;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
    end else if (ir_valid_q && bus.dec_ready) begin
      ir_valid_d = 1'b0;
    end else begin
      ir_valid_d = ir_valid_q;
    end
  end

  // datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      ir_out_q   <= {INSTR_W{1'b0}};
      ir_pc_q    <= {PC_W{1'b0}};
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_out_q   <= ir_out_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.pc_out   = pc_q;
  assign bus.ir_out   = ir_out_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 256x8 combinational memory.
// Expectations for the halt-opcode case follow FETCH_HALT_OPCODE_EN.
module tb_fetch_unit;

  logic clk;
  logic reset;
  logic [7:0] mem [256];
  int tests_run;
  int tests_failed;

  fetch_if #(.PC_W(8), .INSTR_W(8)) bus ();

  assign bus.instr_in = mem[bus.pc_out];

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ctl(input string tag, input logic [7:0] pc, input logic v, input logic h);
    check({tag, ".pc"}, {24'h0, bus.pc_out}, {24'h0, pc});
    check({tag, ".valid"}, {31'h0, bus.ir_valid}, {31'h0, v});
    check({tag, ".halted"}, {31'h0, bus.halted}, {31'h0, h});
  endtask

  task automatic expect_ir(input string tag, input logic [7:0] ir, input logic [7:0] irpc);
    check({tag, ".ir"}, {24'h0, bus.ir_out}, {24'h0, ir});
    check({tag, ".ir_pc"}, {24'h0, bus.ir_pc}, {24'h0, irpc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    reset           = 1'b1;
    bus.dec_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    bus.halt_req    = 1'b0;
    bus.resume      = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = {1'b0, 7'(i)};
    mem[8'h00] = 8'h11;
    mem[8'h01] = 8'h22;
    mem[8'h02] = 8'h33;
    mem[8'h80] = 8'h5A;

    tick();
    tick();
    expect_ctl("rst", 8'h00, 1'b0, 1'b0);
    expect_ir("rst", 8'h00, 8'h00);
    reset         = 1'b0;
    bus.dec_ready = 1'b1;

    // streaming fetch
    tick(); expect_ctl("seq0", 8'h01, 1'b1, 1'b0); expect_ir("seq0", 8'h11, 8'h00);
    tick(); expect_ctl("seq1", 8'h02, 1'b1, 1'b0); expect_ir("seq1", 8'h22, 8'h01);

    // three-cycle stall
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_ctl("stall", 8'h02, 1'b1, 1'b0); expect_ir("stall", 8'h22, 8'h01);
    end
    bus.dec_ready = 1'b1;
    tick(); expect_ctl("unstall", 8'h03, 1'b1, 1'b0); expect_ir("unstall", 8'h33, 8'h02);

    // redirect squashes a stalled IR
    bus.dec_ready = 1'b0;
    tick(); expect_ctl("hold", 8'h03, 1'b1, 1'b0);
    bus.redirect = 1'b1; bus.redirect_pc = 8'h80;
    tick(); expect_ctl("redir", 8'h80, 1'b0, 1'b0);
    bus.redirect = 1'b0; bus.dec_ready = 1'b1;
    tick(); expect_ctl("redir1", 8'h81, 1'b1, 1'b0); expect_ir("redir1", 8'h5A, 8'h80);

    // PC wrap
    bus.redirect = 1'b1; bus.redirect_pc = 8'hFE;
    tick(); expect_ctl("wrap0", 8'hFE, 1'b0, 1'b0);
    bus.redirect = 1'b0;
    tick(); expect_ctl("wrap1", 8'hFF, 1'b1, 1'b0); expect_ir("wrap1", 8'h7E, 8'hFE);
    tick(); expect_ctl("wrap2", 8'h00, 1'b1, 1'b0); expect_ir("wrap2", 8'h7F, 8'hFF);
    tick(); expect_ctl("wrap3", 8'h01, 1'b1, 1'b0); expect_ir("wrap3", 8'h11, 8'h00);

    // halt_req at pc 05 with a valid IR, then resume
    bus.redirect = 1'b1; bus.redirect_pc = 8'h04;
    tick(); expect_ctl("h_pre", 8'h04, 1'b0, 1'b0);
    bus.redirect = 1'b0;
    tick(); expect_ctl("h_fetch", 8'h05, 1'b1, 1'b0); expect_ir("h_fetch", 8'h04, 8'h04);
    bus.halt_req = 1'b1;
    tick(); expect_ctl("h_enter", 8'h05, 1'b0, 1'b1);
    bus.halt_req = 1'b0;
    tick(); expect_ctl("h_stay", 8'h05, 1'b0, 1'b1);
    bus.halt_req = 1'b1; bus.resume = 1'b1;
    tick(); expect_ctl("h_both", 8'h05, 1'b0, 1'b1);
    bus.halt_req = 1'b0;
    tick(); expect_ctl("resume", 8'h05, 1'b0, 1'b0);
    bus.resume = 1'b0;
    tick(); expect_ctl("res_fetch", 8'h06, 1'b1, 1'b0); expect_ir("res_fetch", 8'h05, 8'h05);
    bus.resume = 1'b1;
    tick(); expect_ctl("res_run", 8'h07, 1'b1, 1'b0); expect_ir("res_run", 8'h06, 8'h06);
    bus.resume = 1'b0;

    // halt while stalled: IR drains only once accepted
    bus.dec_ready = 1'b0; bus.halt_req = 1'b1;
    tick(); expect_ctl("hs0", 8'h07, 1'b1, 1'b1);
    bus.halt_req = 1'b0;
    tick(); expect_ctl("hs1", 8'h07, 1'b1, 1'b1);
    bus.dec_ready = 1'b1;
    tick(); expect_ctl("hs2", 8'h07, 1'b0, 1'b1);
    bus.redirect = 1'b1; bus.redirect_pc = 8'h20;
    tick(); expect_ctl("h_redir", 8'h20, 1'b0, 1'b1);
    bus.redirect_pc = 8'h30; bus.resume = 1'b1;
    tick(); expect_ctl("redir_res", 8'h30, 1'b0, 1'b0);
    bus.redirect = 1'b0; bus.resume = 1'b0;
    tick(); expect_ctl("rr_fetch", 8'h31, 1'b1, 1'b0); expect_ir("rr_fetch", 8'h30, 8'h30);

    // halt opcode at address 03
    mem[8'h03] = 8'hFF;
    bus.redirect = 1'b1; bus.redirect_pc = 8'h03;
    tick(); expect_ctl("op_pre", 8'h03, 1'b0, 1'b0);
    bus.redirect = 1'b0;
`ifdef FETCH_HALT_OPCODE_EN
    tick(); expect_ctl("op_hit", 8'h04, 1'b1, 1'b1); expect_ir("op_hit", 8'hFF, 8'h03);
    tick(); expect_ctl("op_drain", 8'h04, 1'b0, 1'b1);
    bus.resume = 1'b1;
    tick(); expect_ctl("op_res", 8'h04, 1'b0, 1'b0);
    bus.resume = 1'b0;
    tick(); expect_ctl("op_next", 8'h05, 1'b1, 1'b0); expect_ir("op_next", 8'h04, 8'h04);
`else
    tick(); expect_ctl("op_hit", 8'h04, 1'b1, 1'b0); expect_ir("op_hit", 8'hFF, 8'h03);
    tick(); expect_ctl("op_next", 8'h05, 1'b1, 1'b0); expect_ir("op_next", 8'h04, 8'h04);
`endif

    // asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    expect_ctl("arst", 8'h00, 1'b0, 1'b0);
    expect_ir("arst", 8'h00, 8'h00);
    tick();
    expect_ctl("arst_hold", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    expect_ctl("post_rst", 8'h01, 1'b1, 1'b0);
    expect_ir("post_rst", 8'h11, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
